// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: hh:mm:ss preset via set/inc, counts down on a 1 Hz tick, raises alarm at zero.
// Latency: every input acts on the next rising clk edge; finish is a registered one-clk pulse on entering DONE.
// No backpressure: single-cycle pulse inputs, always accepted; priority clear > set > start.
module countdown_timer_ctrl #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_set,
  input  logic       i_inc,
  input  logic [1:0] i_sel,
  input  logic       i_clear,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic [2:0] o_state,
  output logic       o_finish,
  output logic       o_alarm
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [5:0] L_SEC_MAX = 6'(SEC_MAX);
  localparam logic [5:0] L_MIN_MAX = 6'(MIN_MAX);
  localparam logic [4:0] L_HR_MAX  = 5'(HR_MAX);

  logic [2:0] r_state;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hr;
  logic       r_finish;

  logic [2:0] w_state_n;
  logic [5:0] w_sec_n;
  logic [5:0] w_min_n;
  logic [4:0] w_hr_n;
  logic       w_finish_n;

  logic [5:0] w_dec_sec;
  logic [5:0] w_dec_min;
  logic [4:0] w_dec_hr;
  logic       w_dec_zero;
  logic       w_time_zero;
  logic [5:0] w_inc_sec;
  logic [5:0] w_inc_min;
  logic [4:0] w_inc_hr;

  // One-second decrement with borrow; only consulted in RUN, where time is never all-zero.
  always_comb begin
    w_dec_sec = r_sec;
    w_dec_min = r_min;
    w_dec_hr  = r_hr;
    if (r_sec != 6'd0) begin
      w_dec_sec = r_sec - 6'd1;
    end else if (r_min != 6'd0) begin
      w_dec_sec = L_SEC_MAX;
      w_dec_min = r_min - 6'd1;
    end else begin
      w_dec_sec = L_SEC_MAX;
      w_dec_min = L_MIN_MAX;
      w_dec_hr  = r_hr - 5'd1;
    end
  end

  assign w_dec_zero  = (w_dec_sec == 6'd0) && (w_dec_min == 6'd0) && (w_dec_hr == 5'd0);
  assign w_time_zero = (r_sec == 6'd0) && (r_min == 6'd0) && (r_hr == 5'd0);

  // Per-field edit increments wrap MAX -> 0 independently (no carry between fields).
  assign w_inc_sec = (r_sec >= L_SEC_MAX) ? 6'd0 : r_sec + 6'd1;
  assign w_inc_min = (r_min >= L_MIN_MAX) ? 6'd0 : r_min + 6'd1;
  assign w_inc_hr  = (r_hr  >= L_HR_MAX)  ? 5'd0 : r_hr  + 5'd1;

  // Next-state and next-time selection, clear first, then per-state set/start/tick/inc handling.
  always_comb begin
    w_state_n  = r_state;
    w_sec_n    = r_sec;
    w_min_n    = r_min;
    w_hr_n     = r_hr;
    w_finish_n = 1'b0;
    if (i_clear) begin
      w_state_n = S_IDLE;
      w_sec_n   = 6'd0;
      w_min_n   = 6'd0;
      w_hr_n    = 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_set) begin
            w_state_n = S_SET;
          end else if (i_start && !w_time_zero) begin
            w_state_n = S_RUN;
          end
        end
        S_SET: begin
          if (i_set) begin
            w_state_n = S_IDLE;
          end
          if (i_inc) begin
            case (i_sel)
              2'd0:    w_sec_n = w_inc_sec;
              2'd1:    w_min_n = w_inc_min;
              2'd2:    w_hr_n  = w_inc_hr;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // A same-cycle tick is dropped on set, but still counts on start.
          if (i_set) begin
            w_state_n = S_IDLE;
          end else begin
            if (i_tick) begin
              w_sec_n = w_dec_sec;
              w_min_n = w_dec_min;
              w_hr_n  = w_dec_hr;
            end
            if (i_tick && w_dec_zero) begin
              w_state_n  = S_DONE;
              w_finish_n = 1'b1;
            end else if (i_start) begin
              w_state_n = S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (i_set) begin
            w_state_n = S_IDLE;
          end else if (i_start) begin
            w_state_n = S_RUN;
          end
        end
        S_DONE: begin
          w_sec_n = 6'd0;
          w_min_n = 6'd0;
          w_hr_n  = 5'd0;
          if (i_set || i_start) begin
            w_state_n = S_IDLE;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // State, time fields and the finish pulse register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sec    <= 6'd0;
      r_min    <= 6'd0;
      r_hr     <= 5'd0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sec    <= w_sec_n;
      r_min    <= w_min_n;
      r_hr     <= w_hr_n;
      r_finish <= w_finish_n;
    end
  end

  assign o_sec    = r_sec;
  assign o_min    = r_min;
  assign o_hr     = r_hr;
  assign o_state  = r_state;
  assign o_finish = r_finish;
  assign o_alarm  = (r_state == S_DONE);

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 Parameter SEC_MAX, default 59, SHALL be the seconds field wrap and reload value.
REQ-002 Parameter MIN_MAX, default 59, SHALL be the minutes field wrap and reload value.
REQ-003 Parameter HR_MAX, default 23, SHALL be the hours field wrap value.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 tick  in  1  SHALL be a one-clk-wide 1 Hz time-base pulse.
REQ-007 start  in  1  SHALL be a one-clk start/pause pulse.
REQ-008 set  in  1  SHALL be a one-clk enter/exit-set-mode pulse.
REQ-009 inc  in  1  SHALL be a one-clk field-increment pulse.
REQ-010 sel  in  2  SHALL select the field to edit: 0 sec, 1 min, 2 hr, 3 none.
REQ-011 clear  in  1  SHALL be a synchronous clear request.
REQ-012 sec  out  6  SHALL be the current seconds value.
REQ-013 min  out  6  SHALL be the current minutes value.
REQ-014 hr  out  5  SHALL be the current hours value.
REQ-015 state  out  3  SHALL encode the FSM: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4.
REQ-016 finish  out  1  SHALL pulse high for exactly one clk on entry to DONE.
REQ-017 alarm  out  1  SHALL be high throughout DONE and low in every other state.

Function
REQ-018 Priority within a cycle SHALL be: clear > set > start; tick and inc SHALL be evaluated alongside these in the cycle they occur.
REQ-019 clear SHALL zero sec, min and hr, and force IDLE, on the next edge from any state.
REQ-020 IDLE: set -> SET; start with nonzero time -> RUN; start with all-zero time SHALL be ignored.
REQ-021 SET: inc SHALL add 1 to the selected field only, wrapping MAX -> 0 with no carry. inc with sel=3 SHALL have no effect.
REQ-022 SET: set -> IDLE; start and tick SHALL be ignored.
REQ-023 RUN: on tick, the block SHALL decrement with borrow as follows:
- sec>0: sec-1.
- else min>0: sec=SEC_MAX, min-1.
- else: sec=SEC_MAX, min=MIN_MAX, hr-1.
REQ-024 RUN: when a decrement yields all-zero time, the next state SHALL be DONE with finish asserted, overriding a same-cycle start.
REQ-025 RUN: start -> PAUSE; a same-cycle tick SHALL still apply its decrement.
REQ-026 RUN: set -> IDLE with time retained; a same-cycle tick SHALL be discarded.
REQ-027 PAUSE: start -> RUN; set -> IDLE; tick SHALL be ignored; time SHALL be held.
REQ-028 DONE: time SHALL hold zero; start or set -> IDLE, clearing alarm on that edge.
REQ-029 inc SHALL be ignored in all states except SET.
REQ-030 finish SHALL be registered and SHALL NOT re-assert while the block remains in DONE.

Reset
REQ-031 While reset=0, the block SHALL hold: state=IDLE, sec=0, min=0, hr=0, finish=0, alarm=0, independent of clk.
REQ-032 Reset deassertion SHALL take effect synchronously on the first rising clk edge after release; no input is acted on before that edge.

Verification
REQ-033 The bench SHALL cover reset mid-RUN (sec=30): reset low between edges -> all outputs zero and state=0 immediately; they remain so after release until an input arrives.
REQ-034 The bench SHALL cover set entry and field edit: set, sel=0, 61 inc pulses, set -> sec=1 (59 -> 0 wrap), min=0, state=0.
REQ-035 The bench SHALL cover a borrow chain: load hr=1, min=0, sec=0; start; one tick -> hr=0, min=59, sec=59, state=2.
REQ-036 The bench SHALL cover expiry: load sec=2; start; two ticks -> finish high exactly 1 clk on the second, state=4, alarm=1; then start -> state=0, alarm=0.
REQ-037 The bench SHALL cover simultaneous events:
- start with tick in RUN at sec=5 -> sec=4, state=3.
- start with tick at sec=1 -> state=4, finish=1.
- set with start in IDLE -> state=1.
REQ-038 The bench SHALL cover a zero start and clear: start in IDLE with zero time -> state stays 0; clear in PAUSE (min=7) -> all fields 0, state=0.
